wavepool_feed_arbiter: RTL and testbench



---
 rtl/wavepool_feed_arbiter.sv | 85 ++++++++
 tb/tb_wavepool_feed_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavepool_feed_arbiter.sv
// Round-robin feed arbiter between the wavepool instruction queues and decode.
// Each slot is locked after a grant until issue releases it or the slot is flushed.
module wavepool_feed_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] valid_wf,
    input  logic [NUM_WF-1:0] q_empty,
    input  logic [NUM_WF-1:0] q_reset,
    input  logic              decode_ready,
    input  logic              issue_done_valid,
    input  logic [WFID_W-1:0] issue_done_wfid,
    output logic [WFID_W-1:0] feed_wfid,
    output logic              feed_valid
);

    localparam logic [WFID_W-1:0] LAST_SLOT = WFID_W'(NUM_WF - 1);

    logic [NUM_WF-1:0] busy;
    logic [WFID_W-1:0] rr_ptr;

    logic [NUM_WF-1:0] eligible;
    logic [NUM_WF-1:0] win_vec;
    logic [NUM_WF-1:0] busy_clr;
    logic [NUM_WF-1:0] busy_set;
    logic [WFID_W-1:0] winner;
    logic              found;
    logic              grant;
    int                idx;

    assign eligible = valid_wf & ~q_empty & ~busy & ~q_reset;
    assign grant    = decode_ready & found;
    assign busy_set = grant ? win_vec : '0;

    // Search order is rr_ptr+1, rr_ptr+2, ... wrapping at NUM_WF, so rr_ptr is seen last.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can hold a
        // stale value and infer a latch.
        found   = 1'b0;
        winner  = '0;
        win_vec = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_WF; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_WF) begin
                idx = idx - NUM_WF;
            end
            if (!found && eligible[idx]) begin
                found        = 1'b1;
                winner       = WFID_W'(idx);
                win_vec[idx] = 1'b1;
            end
        end
    end

    // Out-of-range release ids match no slot and therefore fall through harmlessly.
    always_comb begin
        busy_clr = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            busy_clr[i] = q_reset[i] | (issue_done_valid && (issue_done_wfid == WFID_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            feed_valid <= 1'b0;
            feed_wfid  <= '0;
            busy       <= '0;
            rr_ptr     <= LAST_SLOT;
        end else begin
            feed_valid <= grant;
            if (grant) begin
                feed_wfid <= winner;
                rr_ptr    <= winner;
            end
            // Clear wins over set on the same slot.
            busy <= (busy | busy_set) & ~busy_clr;
        end
    end

endmodule

// File: tb/tb_wavepool_feed_arbiter.sv
// Directed bench for wavepool_feed_arbiter: round-robin order, wrap, back-pressure,
// release latency, flush and mid-run reset, observed on feed_valid/feed_wfid.
module tb_wavepool_feed_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_WF-1:0] valid_wf;
    logic [NUM_WF-1:0] q_empty;
    logic [NUM_WF-1:0] q_reset;
    logic              decode_ready;
    logic              issue_done_valid;
    logic [WFID_W-1:0] issue_done_wfid;
    logic [WFID_W-1:0] feed_wfid;
    logic              feed_valid;

    int tests = 0;
    int fails = 0;

    wavepool_feed_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_wf         (valid_wf),
        .q_empty          (q_empty),
        .q_reset          (q_reset),
        .decode_ready     (decode_ready),
        .issue_done_valid (issue_done_valid),
        .issue_done_wfid  (issue_done_wfid),
        .feed_wfid        (feed_wfid),
        .feed_valid       (feed_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Outputs are sampled and inputs changed 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        valid_wf         = '0;
        q_empty          = '0;
        q_reset          = '0;
        decode_ready     = 1'b0;
        issue_done_valid = 1'b0;
        issue_done_wfid  = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd0}) begin
            fails++;
            $display("FAIL reset_idle: got v=%0b id=%0d, want v=0 id=0", feed_valid, feed_wfid);
        end
        // Reset must override a grant that would otherwise happen this cycle.
        rst          = 1'b1;
        valid_wf[4]  = 1'b1;
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd0}) begin
            fails++;
            $display("FAIL reset_overrides_grant: got v=%0b id=%0d, want v=0 id=0", feed_valid, feed_wfid);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        valid_wf[0]  = 1'b1;
        valid_wf[3]  = 1'b1;
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd0}) begin
            fails++;
            $display("FAIL rr_first: got v=%0b id=%0d, want v=1 id=0", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd3}) begin
            fails++;
            $display("FAIL rr_second: got v=%0b id=%0d, want v=1 id=3", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd3}) begin
            fails++;
            $display("FAIL rr_all_busy: got v=%0b id=%0d, want v=0 id=3", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        valid_wf[38] = 1'b1;
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd38}) begin
            fails++;
            $display("FAIL wrap_seed38: got v=%0b id=%0d, want v=1 id=38", feed_valid, feed_wfid);
        end
        valid_wf     = '0;
        valid_wf[39] = 1'b1;
        valid_wf[1]  = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd39}) begin
            fails++;
            $display("FAIL wrap_top: got v=%0b id=%0d, want v=1 id=39", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd1}) begin
            fails++;
            $display("FAIL wrap_to_low: got v=%0b id=%0d, want v=1 id=1", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd1}) begin
            fails++;
            $display("FAIL wrap_idle: got v=%0b id=%0d, want v=0 id=1", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        valid_wf[7] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({feed_valid, feed_wfid} !== {1'b0, 6'd0}) begin
                fails++;
                $display("FAIL bp_hold_c%0d: got v=%0b id=%0d, want v=0 id=0", c, feed_valid, feed_wfid);
            end
        end
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd7}) begin
            fails++;
            $display("FAIL bp_release: got v=%0b id=%0d, want v=1 id=7", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_release_latency();
        do_reset();
        valid_wf[2]  = 1'b1;
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd2}) begin
            fails++;
            $display("FAIL rel_grant: got v=%0b id=%0d, want v=1 id=2", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd2}) begin
            fails++;
            $display("FAIL rel_locked: got v=%0b id=%0d, want v=0 id=2", feed_valid, feed_wfid);
        end
        issue_done_valid = 1'b1;
        issue_done_wfid  = 6'd2;
        step();
        issue_done_valid = 1'b0;
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd2}) begin
            fails++;
            $display("FAIL rel_no_bypass: got v=%0b id=%0d, want v=0 id=2", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd2}) begin
            fails++;
            $display("FAIL rel_refeed: got v=%0b id=%0d, want v=1 id=2", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        valid_wf[5]  = 1'b1;
        decode_ready = 1'b1;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd5}) begin
            fails++;
            $display("FAIL flush_seed5: got v=%0b id=%0d, want v=1 id=5", feed_valid, feed_wfid);
        end
        valid_wf[9] = 1'b1;
        q_reset[5]  = 1'b1;
        step();
        q_reset[5] = 1'b0;
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd9}) begin
            fails++;
            $display("FAIL flush_other_wins: got v=%0b id=%0d, want v=1 id=9", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd5}) begin
            fails++;
            $display("FAIL flush_unlocked: got v=%0b id=%0d, want v=1 id=5", feed_valid, feed_wfid);
        end
        // Out-of-range release id must not unlock anything.
        issue_done_valid = 1'b1;
        issue_done_wfid  = 6'd45;
        step();
        issue_done_valid = 1'b0;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd5}) begin
            fails++;
            $display("FAIL flush_bad_id: got v=%0b id=%0d, want v=0 id=5", feed_valid, feed_wfid);
        end
        issue_done_valid = 1'b1;
        issue_done_wfid  = 6'd9;
        step();
        issue_done_valid = 1'b0;
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd9}) begin
            fails++;
            $display("FAIL flush_release9: got v=%0b id=%0d, want v=1 id=9", feed_valid, feed_wfid);
        end
        // q_reset on the slot that would otherwise win at this edge.
        do_reset();
        valid_wf[4]  = 1'b1;
        valid_wf[6]  = 1'b1;
        q_reset[4]   = 1'b1;
        decode_ready = 1'b1;
        step();
        q_reset[4] = 1'b0;
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd6}) begin
            fails++;
            $display("FAIL flush_mask_candidate: got v=%0b id=%0d, want v=1 id=6", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid_wf[0]  = 1'b1;
        valid_wf[1]  = 1'b1;
        valid_wf[2]  = 1'b1;
        decode_ready = 1'b1;
        step();
        step();
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd2}) begin
            fails++;
            $display("FAIL mid_prefill: got v=%0b id=%0d, want v=1 id=2", feed_valid, feed_wfid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b0, 6'd0}) begin
            fails++;
            $display("FAIL mid_reset: got v=%0b id=%0d, want v=0 id=0", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd0}) begin
            fails++;
            $display("FAIL mid_first_grant: got v=%0b id=%0d, want v=1 id=0", feed_valid, feed_wfid);
        end
        step();
        tests++;
        if ({feed_valid, feed_wfid} !== {1'b1, 6'd1}) begin
            fails++;
            $display("FAIL mid_second_grant: got v=%0b id=%0d, want v=1 id=1", feed_valid, feed_wfid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_release_latency();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
